cfg_loader: RTL and testbench

Responder for the control unit's configuration request. While CFG_Req is high, it pulls a fixed-length burst of configuration words from the host interface using a valid/ready handshake. It stores the words in a register bank and pulses IFCFG_RdDone once the last word is captured. IFCFG_Val is held high while a complete, current configuration sits in the bank.

---
 rtl/cfg_loader.sv | 121 ++++++++++++
 tb/tb_cfg_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cfg_loader.sv
// Configuration loader: on a control-unit request, pulls NUM_WORDS words from the
// host over a valid/ready handshake into a register bank and flags the bank valid.
module cfg_loader #(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_WORDS  = 8,
    localparam int CNT_WIDTH  = $clog2(NUM_WORDS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            CFG_Req,
    output logic                            IFCFG_RdDone,
    output logic                            IFCFG_Val,
    output logic                            IF_Req,
    input  logic [DATA_WIDTH-1:0]           IF_Dat,
    input  logic                            IF_DatVal,
    output logic                            IF_DatRdy,
    output logic                            CFG_Wr,
    output logic [CNT_WIDTH-1:0]            CFG_Addr,
    output logic [NUM_WORDS*DATA_WIDTH-1:0] CFG_Regs,
    output logic [1:0]                      dbg_state
);

    // Handshake: a word moves on every cycle where IF_DatRdy and IF_DatVal are both high;
    // the host may hold IF_DatVal low for any number of cycles without losing position.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_WORDS - 1);

    state_t                          state_q, state_d;
    logic [CNT_WIDTH-1:0]            cnt_q, cnt_d;
    logic [NUM_WORDS*DATA_WIDTH-1:0] regs_q, regs_d;
    logic                            val_q, val_d;
    logic                            wr_q, wr_d;
    logic [CNT_WIDTH-1:0]            addr_q, addr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            regs_q  <= '0;
            val_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            regs_q  <= regs_d;
            val_q   <= val_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        val_d   = val_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (CFG_Req) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    val_d   = 1'b0;
                end
            end
            RECV: begin
                if (IF_DatVal) begin
                    for (int i = 0; i < NUM_WORDS; i++) begin
                        if (cnt_q == CNT_WIDTH'(i)) begin
                            regs_d[i*DATA_WIDTH +: DATA_WIDTH] = IF_Dat;
                        end
                    end
                    wr_d   = 1'b1;
                    addr_d = cnt_q;
                    // Completion takes priority over a request dropped on the last word.
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else if (!CFG_Req) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (!CFG_Req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                val_d   = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (!CFG_Req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign IF_Req       = (state_q == RECV);
    assign IF_DatRdy    = (state_q == RECV);
    assign IFCFG_RdDone = (state_q == DONE);
    assign IFCFG_Val    = val_q;
    assign CFG_Wr       = wr_q;
    assign CFG_Addr     = addr_q;
    assign CFG_Regs     = regs_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_cfg_loader.sv
// Directed bench for cfg_loader: table of load scenarios plus reset checks,
// with a bank model updated from the words the bench itself hands over.
module tb_cfg_loader;

    localparam int DW = 32;
    localparam int NW = 8;
    localparam int CW = $clog2(NW);

    logic              clk;
    logic              rst_n;
    logic              CFG_Req;
    logic              IFCFG_RdDone;
    logic              IFCFG_Val;
    logic              IF_Req;
    logic [DW-1:0]     IF_Dat;
    logic              IF_DatVal;
    logic              IF_DatRdy;
    logic              CFG_Wr;
    logic [CW-1:0]     CFG_Addr;
    logic [NW*DW-1:0]  CFG_Regs;
    logic [1:0]        dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_bank [NW];

    typedef struct {
        logic [7:0] base;
        int         stall_n;
        int         abort_after;
        int         reset_after;
        bit         drop_last;
        int         hold_extra;
        int         exp_lat;
        int         exp_done;
        int         exp_wr;
    } vec_t;

    vec_t vecs [6];

    cfg_loader #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .CFG_Req      (CFG_Req),
        .IFCFG_RdDone (IFCFG_RdDone),
        .IFCFG_Val    (IFCFG_Val),
        .IF_Req       (IF_Req),
        .IF_Dat       (IF_Dat),
        .IF_DatVal    (IF_DatVal),
        .IF_DatRdy    (IF_DatRdy),
        .CFG_Wr       (CFG_Wr),
        .CFG_Addr     (CFG_Addr),
        .CFG_Regs     (CFG_Regs),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_rddone", 64'(IFCFG_RdDone), 64'd0);
        chk("rst_val", 64'(IFCFG_Val), 64'd0);
        chk("rst_ifreq", 64'(IF_Req), 64'd0);
        chk("rst_rdy", 64'(IF_DatRdy), 64'd0);
        chk("rst_wr", 64'(CFG_Wr), 64'd0);
        chk("rst_addr", 64'(CFG_Addr), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
        for (int i = 0; i < NW; i++) begin
            chk($sformatf("rst_reg%0d", i), 64'(CFG_Regs[i*DW +: DW]), 64'd0);
        end
    endtask

    task automatic chk_bank(input string tag);
        for (int i = 0; i < NW; i++) begin
            chk($sformatf("%s_reg%0d", tag, i), 64'(CFG_Regs[i*DW +: DW]), 64'(exp_bank[i]));
        end
    endtask

    task automatic run_vec(input int vn, input vec_t v);
        int   idx, cyc, stall, lat, n_done, n_wr, wr_idx;
        logic drv_val;
        bit   fin, dropped, was_reset;
        idx = 0; cyc = 0; stall = 0; lat = -1; n_done = 0; n_wr = 0; wr_idx = 0;
        fin = 0; dropped = 0; was_reset = 0;
        @(negedge clk);
        CFG_Req = 1'b1;
        while (!fin && cyc < 200) begin
            drv_val = IF_DatRdy && (stall == 0) && (idx < NW);
            if (v.abort_after >= 0 && idx == v.abort_after) begin
                drv_val = 1'b0;
                CFG_Req = 1'b0;
                dropped = 1'b1;
            end
            if (v.drop_last && drv_val && idx == NW - 1) CFG_Req = 1'b0;
            IF_DatVal = drv_val;
            IF_Dat    = drv_val ? DW'(v.base + 8'(idx)) : 32'hDEADBEEF;
            if (v.reset_after >= 0 && idx == v.reset_after) begin
                IF_DatVal = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                chk_reset_state();
                for (int i = 0; i < NW; i++) exp_bank[i] = '0;
                @(negedge clk);
                rst_n     = 1'b1;
                CFG_Req   = 1'b0;
                fin       = 1'b1;
                was_reset = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
                if (drv_val) begin
                    exp_bank[idx] = DW'(v.base + 8'(idx));
                    idx++;
                    if (v.stall_n > 0 && (idx == 3 || idx == 6)) stall = v.stall_n;
                end else if (stall > 0) begin
                    stall--;
                end
                if (CFG_Wr) begin
                    chk($sformatf("v%0d_addr", vn), 64'(CFG_Addr), 64'(wr_idx));
                    wr_idx++;
                    n_wr++;
                end
                if (IFCFG_RdDone) begin
                    n_done++;
                    if (lat < 0) lat = cyc;
                    fin = 1'b1;
                end else if (dropped) begin
                    fin = 1'b1;
                end else begin
                    chk($sformatf("v%0d_val_low", vn), 64'(IFCFG_Val), 64'd0);
                end
            end
        end
        IF_DatVal = 1'b0;
        if (!fin) begin
            failures++;
            $display("FAIL v%0d_timeout actual=%0d required=done", vn, cyc);
            CFG_Req = 1'b0;
        end
        if (was_reset) return;
        chk($sformatf("v%0d_nwr", vn), 64'(n_wr), 64'(v.exp_wr));
        chk($sformatf("v%0d_ndone", vn), 64'(n_done), 64'(v.exp_done));
        if (v.exp_done > 0) begin
            chk($sformatf("v%0d_lat", vn), 64'(lat), 64'(v.exp_lat));
            for (int k = 0; k < v.hold_extra; k++) begin
                @(negedge clk);
                chk($sformatf("v%0d_hold_done", vn), 64'(IFCFG_RdDone), 64'd0);
                chk($sformatf("v%0d_hold_ifreq", vn), 64'(IF_Req), 64'd0);
                chk($sformatf("v%0d_hold_state", vn), 64'(dbg_state), 64'd3);
                chk($sformatf("v%0d_hold_val", vn), 64'(IFCFG_Val), 64'd1);
            end
            CFG_Req = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_val_post", vn), 64'(IFCFG_Val), 64'd1);
            chk($sformatf("v%0d_ifreq_post", vn), 64'(IF_Req), 64'd0);
            @(negedge clk);
            chk($sformatf("v%0d_val_idle", vn), 64'(IFCFG_Val), 64'd1);
            chk($sformatf("v%0d_idle_state", vn), 64'(dbg_state), 64'd0);
        end else begin
            chk($sformatf("v%0d_val_abort", vn), 64'(IFCFG_Val), 64'd0);
            chk($sformatf("v%0d_ifreq_abort", vn), 64'(IF_Req), 64'd0);
            chk($sformatf("v%0d_state_abort", vn), 64'(dbg_state), 64'd0);
        end
        chk_bank($sformatf("v%0d", vn));
    endtask

    initial begin
        //          base   stall abort reset drop hold lat done wr
        vecs[0] = '{8'h10, 0,    -1,   -1,   0,   5,   9,  1,   8};
        vecs[1] = '{8'h10, 3,    -1,   -1,   0,   0,   15, 1,   8};
        vecs[2] = '{8'h40, 0,    3,    -1,   0,   0,   0,  0,   3};
        vecs[3] = '{8'h20, 0,    -1,   -1,   0,   0,   9,  1,   8};
        vecs[4] = '{8'h50, 0,    -1,   4,    0,   0,   0,  0,   0};
        vecs[5] = '{8'h60, 0,    -1,   -1,   1,   0,   9,  1,   8};

        for (int i = 0; i < NW; i++) exp_bank[i] = '0;
        rst_n     = 1'b0;
        CFG_Req   = 1'b0;
        IF_Dat    = '0;
        IF_DatVal = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state();
        rst_n = 1'b1;
        @(negedge clk);
        IF_DatVal = 1'b1;
        IF_Dat    = 32'hCAFEF00D;
        @(negedge clk);
        chk("idle_ignores_dat_wr", 64'(CFG_Wr), 64'd0);
        chk("idle_ignores_dat_reg0", 64'(CFG_Regs[DW-1:0]), 64'd0);
        IF_DatVal = 1'b0;

        for (int n = 0; n < 6; n++) begin
            run_vec(n, vecs[n]);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0t required=finished", $time);
        $fatal(1, "timeout");
    end

endmodule
